// File: rtl/cart_load_ctrl.sv
// Steers HPS ioctl downloads into the cart/BIOS RAM write ports, strips the A78
// header, derives cart size/mask and holds the console in reset until a cart is loaded.
module cart_load_ctrl #(
    parameter int HOLD_CYCLES = 16,
    parameter int HDR_LEN     = 128
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        ioctl_download,
    input  logic [7:0]  ioctl_index,
    input  logic [24:0] ioctl_addr,
    input  logic [7:0]  ioctl_dout,
    input  logic        ioctl_wr,
    output logic        cart_we,
    output logic [17:0] cart_waddr,
    output logic        bios_we,
    output logic [11:0] bios_waddr,
    output logic [7:0]  wdata,
    output logic        cart_is_7800,
    output logic [31:0] cart_size,
    output logic [17:0] cart_mask,
    output logic [15:0] cart_flags,
    output logic [7:0]  joy0_type,
    output logic [7:0]  joy1_type,
    output logic        cart_region,
    output logic [7:0]  cart_save,
    output logic        hold_reset,
    output logic        load_done
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_CART_HDR  = 3'd1,
        S_CART_BODY = 3'd2,
        S_BIOS      = 3'd3,
        S_FINISH    = 3'd4
    } state_t;

    localparam logic [24:0] HDR_LEN_A = 25'(HDR_LEN);
    localparam logic [17:0] HDR_LEN_R = 18'(HDR_LEN);
    localparam logic [31:0] HDR_LEN_W = 32'(HDR_LEN);
    localparam logic [15:0] HOLD_INIT = 16'(HOLD_CYCLES);

    // Expected "ATARI" signature byte for header positions 1..5.
    function automatic logic [7:0] magic_byte(input logic [2:0] idx);
        logic [7:0] b;
        case (idx)
            3'd1:    b = 8'h41;
            3'd2:    b = 8'h54;
            3'd3:    b = 8'h41;
            3'd4:    b = 8'h52;
            3'd5:    b = 8'h49;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // Smear size-1 down to all-ones below its MSB, then clamp to the RAM span.
    function automatic logic [17:0] size_to_mask(input logic [31:0] size);
        logic [31:0] v;
        logic [17:0] m;
        v = size - 32'd1;
        v = v | (v >> 1);
        v = v | (v >> 2);
        v = v | (v >> 4);
        v = v | (v >> 8);
        v = v | (v >> 16);
        if (size <= 32'd1) begin
            m = 18'd0;
        end else if (v > 32'h0003_FFFF) begin
            m = 18'h3FFFF;
        end else begin
            m = v[17:0];
        end
        return m;
    endfunction

    state_t      state_q, state_d;
    logic        dl_q;
    logic        is_cart_q, is_cart_d;
    logic        written_q, written_d;
    logic        magic_ok_q, magic_ok_d;
    logic [24:0] last_addr_q, last_addr_d;
    logic        cart_is_7800_q, cart_is_7800_d;
    logic [31:0] cart_size_q, cart_size_d;
    logic [17:0] cart_mask_q, cart_mask_d;
    logic [15:0] cart_flags_q, cart_flags_d;
    logic [7:0]  joy0_q, joy0_d;
    logic [7:0]  joy1_q, joy1_d;
    logic        region_q, region_d;
    logic [7:0]  save_q, save_d;
    logic        cart_we_q, cart_we_d;
    logic [17:0] cart_waddr_q, cart_waddr_d;
    logic        bios_we_q, bios_we_d;
    logic [11:0] bios_waddr_q, bios_waddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        loaded_q, loaded_d;
    logic        load_done_q, load_done_d;
    logic [15:0] hold_cnt_q, hold_cnt_d;

    logic        dl_rise, dl_fall, hdr_write, magic_pos;
    logic [17:0] body_addr;
    logic [31:0] size_calc;

    assign dl_rise   = ioctl_download & ~dl_q;
    assign dl_fall   = ~ioctl_download & dl_q;
    assign hdr_write = (state_q == S_CART_HDR) && (ioctl_addr < HDR_LEN_A);
    assign magic_pos = (ioctl_addr >= 25'd1) && (ioctl_addr <= 25'd5);
    assign body_addr = ioctl_addr[17:0] - (cart_is_7800_q ? HDR_LEN_R : 18'd0);
    assign size_calc = (cart_is_7800_q && (last_addr_q < HDR_LEN_A)) ? 32'd0 :
                       ({7'd0, last_addr_q} + 32'd1 - (cart_is_7800_q ? HDR_LEN_W : 32'd0));

    // Next-state and datapath decode for the download sequencer.
    always_comb begin
        state_d        = state_q;
        is_cart_d      = is_cart_q;
        written_d      = written_q;
        magic_ok_d     = magic_ok_q;
        last_addr_d    = last_addr_q;
        cart_is_7800_d = cart_is_7800_q;
        cart_size_d    = cart_size_q;
        cart_mask_d    = cart_mask_q;
        cart_flags_d   = cart_flags_q;
        joy0_d         = joy0_q;
        joy1_d         = joy1_q;
        region_d       = region_q;
        save_d         = save_q;
        cart_we_d      = 1'b0;
        cart_waddr_d   = cart_waddr_q;
        bios_we_d      = 1'b0;
        bios_waddr_d   = bios_waddr_q;
        wdata_d        = wdata_q;
        loaded_d       = loaded_q;
        load_done_d    = 1'b0;
        hold_cnt_d     = hold_cnt_q;

        case (state_q)
            S_IDLE: begin
                hold_cnt_d = (hold_cnt_q != 16'd0) ? (hold_cnt_q - 16'd1) : 16'd0;
                if (dl_rise && (ioctl_index != 8'd0)) begin
                    state_d        = S_CART_HDR;
                    is_cart_d      = 1'b1;
                    written_d      = 1'b0;
                    magic_ok_d     = 1'b1;
                    last_addr_d    = 25'd0;
                    cart_is_7800_d = 1'b0;
                    cart_flags_d   = 16'd0;
                    joy0_d         = 8'd0;
                    joy1_d         = 8'd0;
                    region_d       = 1'b0;
                    save_d         = 8'd0;
                end else if (dl_rise) begin
                    state_d   = S_BIOS;
                    is_cart_d = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CART_HDR, S_CART_BODY: begin
                if (ioctl_wr && hdr_write) begin
                    written_d    = 1'b1;
                    last_addr_d  = ioctl_addr;
                    wdata_d      = ioctl_dout;
                    cart_we_d    = ~cart_is_7800_q;
                    cart_waddr_d = ioctl_addr[17:0];
                    if (magic_pos && (ioctl_dout != magic_byte(ioctl_addr[2:0]))) begin
                        magic_ok_d = 1'b0;
                    end else begin
                        magic_ok_d = magic_ok_q;
                    end
                    // Signature verdict lands with byte 5, so byte 5 itself still reaches RAM.
                    if (ioctl_addr == 25'd5) begin
                        cart_is_7800_d = magic_ok_d;
                    end else begin
                        cart_is_7800_d = cart_is_7800_q;
                    end
                    case (ioctl_addr)
                        25'd53:  cart_flags_d[15:8] = ioctl_dout;
                        25'd54:  cart_flags_d[7:0]  = ioctl_dout;
                        25'd55:  joy0_d             = ioctl_dout;
                        25'd56:  joy1_d             = ioctl_dout;
                        25'd57:  region_d           = ioctl_dout[0];
                        25'd58:  save_d             = ioctl_dout;
                        default: begin end
                    endcase
                end else if (ioctl_wr) begin
                    written_d    = 1'b1;
                    last_addr_d  = ioctl_addr;
                    wdata_d      = ioctl_dout;
                    cart_we_d    = 1'b1;
                    cart_waddr_d = body_addr;
                end else begin
                    written_d = written_q;
                end
                state_d = dl_fall ? S_FINISH :
                          ((ioctl_wr && !hdr_write) ? S_CART_BODY : state_q);
            end
            S_BIOS: begin
                if (ioctl_wr && (ioctl_addr < 25'd4096)) begin
                    bios_we_d    = 1'b1;
                    bios_waddr_d = ioctl_addr[11:0];
                    wdata_d      = ioctl_dout;
                end else begin
                    bios_we_d = 1'b0;
                end
                state_d = dl_fall ? S_FINISH : S_BIOS;
            end
            S_FINISH: begin
                state_d = S_IDLE;
                if (is_cart_q && written_q) begin
                    cart_size_d = size_calc;
                    cart_mask_d = size_to_mask(size_calc);
                    load_done_d = 1'b1;
                    loaded_d    = 1'b1;
                    hold_cnt_d  = HOLD_INIT;
                end else if (is_cart_q) begin
                    cart_size_d = 32'd0;
                end else begin
                    cart_size_d = cart_size_q;
                end
                if (is_cart_q && !cart_is_7800_q) begin
                    cart_flags_d = 16'd0;
                    joy0_d       = 8'd0;
                    joy1_d       = 8'd0;
                    region_d     = 1'b0;
                    save_d       = 8'd0;
                end else begin
                    cart_flags_d = cart_flags_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_sys) begin
        if (reset) begin
            state_q        <= S_IDLE;
            // Pretend download was already high so a download in flight at reset
            // release is not mistaken for a fresh rising edge.
            dl_q           <= 1'b1;
            is_cart_q      <= 1'b0;
            written_q      <= 1'b0;
            magic_ok_q     <= 1'b0;
            last_addr_q    <= 25'd0;
            cart_is_7800_q <= 1'b0;
            cart_size_q    <= 32'd0;
            cart_mask_q    <= 18'd0;
            cart_flags_q   <= 16'd0;
            joy0_q         <= 8'd0;
            joy1_q         <= 8'd0;
            region_q       <= 1'b0;
            save_q         <= 8'd0;
            cart_we_q      <= 1'b0;
            cart_waddr_q   <= 18'd0;
            bios_we_q      <= 1'b0;
            bios_waddr_q   <= 12'd0;
            wdata_q        <= 8'd0;
            loaded_q       <= 1'b0;
            load_done_q    <= 1'b0;
            hold_cnt_q     <= 16'd0;
        end else begin
            state_q        <= state_d;
            dl_q           <= ioctl_download;
            is_cart_q      <= is_cart_d;
            written_q      <= written_d;
            magic_ok_q     <= magic_ok_d;
            last_addr_q    <= last_addr_d;
            cart_is_7800_q <= cart_is_7800_d;
            cart_size_q    <= cart_size_d;
            cart_mask_q    <= cart_mask_d;
            cart_flags_q   <= cart_flags_d;
            joy0_q         <= joy0_d;
            joy1_q         <= joy1_d;
            region_q       <= region_d;
            save_q         <= save_d;
            cart_we_q      <= cart_we_d;
            cart_waddr_q   <= cart_waddr_d;
            bios_we_q      <= bios_we_d;
            bios_waddr_q   <= bios_waddr_d;
            wdata_q        <= wdata_d;
            loaded_q       <= loaded_d;
            load_done_q    <= load_done_d;
            hold_cnt_q     <= hold_cnt_d;
        end
    end

    assign cart_we      = cart_we_q;
    assign cart_waddr   = cart_waddr_q;
    assign bios_we      = bios_we_q;
    assign bios_waddr   = bios_waddr_q;
    assign wdata        = wdata_q;
    assign cart_is_7800 = cart_is_7800_q;
    assign cart_size    = cart_size_q;
    assign cart_mask    = cart_mask_q;
    assign cart_flags   = cart_flags_q;
    assign joy0_type    = joy0_q;
    assign joy1_type    = joy1_q;
    assign cart_region  = region_q;
    assign cart_save    = save_q;
    assign load_done    = load_done_q;
    assign hold_reset   = reset | ~loaded_q | ioctl_download | (hold_cnt_q != 16'd0);

endmodule

// File: tb/tb_cart_load_ctrl.sv
// Scoreboard bench for cart_load_ctrl: stimulus queues expected RAM writes and
// load results, a negedge monitor pops and compares them as the DUT emits them.
module tb_cart_load_ctrl;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ioctl_download;
    logic [7:0]  ioctl_index;
    logic [24:0] ioctl_addr;
    logic [7:0]  ioctl_dout;
    logic        ioctl_wr;
    logic        cart_we;
    logic [17:0] cart_waddr;
    logic        bios_we;
    logic [11:0] bios_waddr;
    logic [7:0]  wdata;
    logic        cart_is_7800;
    logic [31:0] cart_size;
    logic [17:0] cart_mask;
    logic [15:0] cart_flags;
    logic [7:0]  joy0_type;
    logic [7:0]  joy1_type;
    logic        cart_region;
    logic [7:0]  cart_save;
    logic        hold_reset;
    logic        load_done;

    cart_load_ctrl #(.HOLD_CYCLES(16), .HDR_LEN(128)) dut (
        .clk_sys(clk_sys), .reset(reset), .ioctl_download(ioctl_download),
        .ioctl_index(ioctl_index), .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout),
        .ioctl_wr(ioctl_wr), .cart_we(cart_we), .cart_waddr(cart_waddr),
        .bios_we(bios_we), .bios_waddr(bios_waddr), .wdata(wdata),
        .cart_is_7800(cart_is_7800), .cart_size(cart_size), .cart_mask(cart_mask),
        .cart_flags(cart_flags), .joy0_type(joy0_type), .joy1_type(joy1_type),
        .cart_region(cart_region), .cart_save(cart_save), .hold_reset(hold_reset),
        .load_done(load_done)
    );

    always #5 clk_sys = ~clk_sys;

    int errors = 0;
    int checks = 0;
    logic [26:0] wq[$];
    logic [49:0] lq[$];
    logic [26:0] w_exp, w_got;
    logic [49:0] l_exp, l_got;

    // Monitor: every RAM write and every load_done pulse must match the queue head.
    always @(negedge clk_sys) begin
        if (cart_we || bios_we) begin
            checks++;
            w_got = cart_we ? {1'b0, cart_waddr, wdata} : {1'b1, 6'd0, bios_waddr, wdata};
            if (wq.size() == 0) begin
                errors++;
                $display("FAIL ram_write: got %h, expected no write", w_got);
            end else begin
                w_exp = wq.pop_front();
                if (w_got !== w_exp) begin
                    errors++;
                    $display("FAIL ram_write: got %h, expected %h", w_got, w_exp);
                end
            end
        end
        if (load_done) begin
            checks++;
            l_got = {cart_size, cart_mask};
            if (lq.size() == 0) begin
                errors++;
                $display("FAIL load_done: got pulse size=%0d mask=%h, expected none", cart_size, cart_mask);
            end else begin
                l_exp = lq.pop_front();
                if (l_got !== l_exp) begin
                    errors++;
                    $display("FAIL load_done: got size=%0d mask=%h, expected size=%0d mask=%h",
                             cart_size, cart_mask, l_exp[49:18], l_exp[17:0]);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic settle(input int n);
        repeat (n) begin
            @(negedge clk_sys);
            ioctl_wr = 1'b0;
        end
    endtask

    // mode 0: plain pattern, 1: A78 header, 2: near-miss "ATARX" header.
    function automatic logic [7:0] file_byte(input int mode, input int a);
        logic [31:0] av;
        logic [7:0]  p;
        av = a;
        p  = av[7:0] ^ av[15:8] ^ 8'h5A;
        if (mode != 0) begin
            case (a)
                1:       p = 8'h41;
                2:       p = 8'h54;
                3:       p = 8'h41;
                4:       p = 8'h52;
                5:       p = (mode == 1) ? 8'h49 : 8'h58;
                default: p = p;
            endcase
        end
        if (mode == 1) begin
            case (a)
                0:       p = 8'h01;
                53:      p = 8'h00;
                54:      p = 8'h02;
                55:      p = 8'h01;
                56:      p = 8'h02;
                57:      p = 8'h01;
                58:      p = 8'h01;
                default: p = p;
            endcase
        end
        return p;
    endfunction

    task automatic start_dl(input logic [7:0] idx);
        @(negedge clk_sys);
        ioctl_wr       = 1'b0;
        ioctl_index    = idx;
        ioctl_download = 1'b1;
        @(negedge clk_sys);
        // Index changes mid-download must not reclassify the transfer.
        ioctl_index = 8'hFF - idx;
    endtask

    // Sends a whole file at full rate; the last byte coincides with download falling.
    task automatic send_file(input logic [7:0] idx, input int len, input int mode);
        logic [24:0] a, b;
        logic [7:0]  d;
        start_dl(idx);
        for (int i = 0; i < len; i++) begin
            a = 25'(i);
            d = file_byte(mode, i);
            if (idx == 8'd0) begin
                if (i < 4096) wq.push_back({1'b1, 6'd0, a[11:0], d});
            end else if (mode == 1) begin
                if (i < 6) begin
                    wq.push_back({1'b0, a[17:0], d});
                end else if (i >= 128) begin
                    b = a - 25'd128;
                    wq.push_back({1'b0, b[17:0], d});
                end
            end else begin
                wq.push_back({1'b0, a[17:0], d});
            end
            @(negedge clk_sys);
            ioctl_wr   = 1'b1;
            ioctl_addr = a;
            ioctl_dout = d;
            if (i == len - 1) ioctl_download = 1'b0;
        end
        if (len == 0) begin
            @(negedge clk_sys);
            ioctl_download = 1'b0;
        end
    endtask

    initial begin
        int n;
        reset          = 1'b1;
        ioctl_download = 1'b0;
        ioctl_index    = 8'd0;
        ioctl_addr     = 25'd0;
        ioctl_dout     = 8'd0;
        ioctl_wr       = 1'b0;
        repeat (3) @(negedge clk_sys);
        chk("rst_hold_reset", {31'd0, hold_reset}, 32'd1);
        chk("rst_cart_we", {31'd0, cart_we}, 32'd0);
        chk("rst_bios_we", {31'd0, bios_we}, 32'd0);
        chk("rst_cart_size", cart_size, 32'd0);
        chk("rst_cart_mask", {14'd0, cart_mask}, 32'd0);
        chk("rst_load_done", {31'd0, load_done}, 32'd0);
        @(negedge clk_sys);
        reset = 1'b0;
        settle(2);
        chk("hold_no_cart", {31'd0, hold_reset}, 32'd1);

        // BIOS, 4100 bytes: only the first 4096 reach RAM.
        send_file(8'd0, 4100, 0);
        settle(20);
        chk("bios_hold_reset", {31'd0, hold_reset}, 32'd1);
        chk("bios_cart_size", cart_size, 32'd0);

        // Empty cart download before any cart load.
        send_file(8'd1, 0, 0);
        settle(20);
        chk("empty1_size", cart_size, 32'd0);
        chk("empty1_hold_reset", {31'd0, hold_reset}, 32'd1);

        // A26, 4096 bytes.
        lq.push_back({32'd4096, 18'h00FFF});
        send_file(8'd1, 4096, 0);
        n = 0;
        do begin
            @(negedge clk_sys);
            ioctl_wr = 1'b0;
            n++;
        end while (hold_reset && n < 100);
        chk("a26_hold_release_cycles", n, 32'd18);
        chk("a26_is_7800", {31'd0, cart_is_7800}, 32'd0);
        chk("a26_size", cart_size, 32'd4096);

        // A78, 128-byte header plus 48 KiB payload.
        lq.push_back({32'd49152, 18'h0FFFF});
        send_file(8'd2, 128 + 49152, 1);
        settle(20);
        chk("a78_is_7800", {31'd0, cart_is_7800}, 32'd1);
        chk("a78_flags", {16'd0, cart_flags}, 32'h0002);
        chk("a78_joy0", {24'd0, joy0_type}, 32'd1);
        chk("a78_joy1", {24'd0, joy1_type}, 32'd2);
        chk("a78_region", {31'd0, cart_region}, 32'd1);
        chk("a78_save", {24'd0, cart_save}, 32'd1);
        chk("a78_mask", {14'd0, cart_mask}, 32'h0FFFF);
        chk("a78_hold_reset", {31'd0, hold_reset}, 32'd0);

        // Near-miss header "ATARX": plain cart, header fields cleared.
        lq.push_back({32'd200, 18'h000FF});
        send_file(8'd3, 200, 2);
        settle(20);
        chk("miss_is_7800", {31'd0, cart_is_7800}, 32'd0);
        chk("miss_flags", {16'd0, cart_flags}, 32'd0);
        chk("miss_joy0", {24'd0, joy0_type}, 32'd0);
        chk("miss_size", cart_size, 32'd200);

        // Empty cart after a successful load: size clears, loaded stays.
        send_file(8'd1, 0, 0);
        settle(20);
        chk("empty2_size", cart_size, 32'd0);
        chk("empty2_hold_reset", {31'd0, hold_reset}, 32'd0);

        // Reset at byte 1000 of a cart download; writes keep coming.
        start_dl(8'd1);
        for (int i = 0; i < 1000; i++) begin
            wq.push_back({1'b0, 18'(i), file_byte(0, i)});
            @(negedge clk_sys);
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = file_byte(0, i);
        end
        for (int i = 1000; i < 1100; i++) begin
            @(negedge clk_sys);
            reset      = (i < 1002);
            ioctl_wr   = 1'b1;
            ioctl_addr = 25'(i);
            ioctl_dout = file_byte(0, i);
        end
        chk("midrst_hold_reset", {31'd0, hold_reset}, 32'd1);
        chk("midrst_cart_size", cart_size, 32'd0);
        @(negedge clk_sys);
        ioctl_wr       = 1'b0;
        ioctl_download = 1'b0;
        settle(20);
        chk("midrst_not_loaded", {31'd0, hold_reset}, 32'd1);

        // The next download is accepted normally.
        lq.push_back({32'd10, 18'h0000F});
        send_file(8'd1, 10, 0);
        settle(25);
        chk("after_rst_hold_reset", {31'd0, hold_reset}, 32'd0);

        chk("write_queue_drained", wq.size(), 32'd0);
        chk("load_queue_drained", lq.size(), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
